// File: rtl/joypad_scanner.sv
// Game Boy joypad front end: synchronises and debounces the 8 raw buttons,
// raises the press interrupt and mirrors the state into RAM as two active-low bytes.
module joypad_scanner #(
  parameter logic [15:0] BTN_ADDR        = 16'hFF00,
  parameter int unsigned DEBOUNCE_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] btn_raw,
  output logic [7:0] btn_state,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       joy_irq,
  output logic       busy
);

  localparam int unsigned    CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0]    DIR_ADDR = BTN_ADDR + 16'd1;

  typedef enum logic [2:0] {
    IDLE, A_HI, A_LO, A_WR, D_HI, D_LO, D_WR
  } state_t;

  state_t          r_state, w_state_next;
  logic [7:0]      r_s1, r_s2, r_btn, r_snap;
  logic [CW-1:0]   r_cnt [8];
  logic [CW-1:0]   w_cnt_next [8];
  logic [7:0]      w_btn_next;
  logic            r_irq, r_chg, r_init, r_pend;
  logic            w_start;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= btn_raw;
      r_s2 <= r_s1;
    end
  end

  // The flip happens on the D-th consecutive mismatch, so the counter never
  // needs to hold D itself.
  always_comb begin
    w_btn_next = r_btn;
    for (int unsigned i = 0; i < 8; i++) begin
      w_cnt_next[i] = '0;
      if (r_s2[i] != r_btn[i]) begin
        if (r_cnt[i] == CNT_LAST)
          w_btn_next[i] = r_s2[i];
        else
          w_cnt_next[i] = r_cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '{default: '0};
      r_btn <= '0;
      r_irq <= 1'b0;
      r_chg <= 1'b0;
    end else begin
      r_cnt <= w_cnt_next;
      r_btn <= w_btn_next;
      r_irq <= |(w_btn_next & ~r_btn);
      r_chg <= (w_btn_next != r_btn);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    wr_en        = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;
    busy         = 1'b1;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (r_init || r_chg || r_pend) begin
          w_state_next = A_HI;
          w_start      = 1'b1;
        end
      end
      A_HI: begin
        wr_addr      = BTN_ADDR[15:8];
        w_state_next = A_LO;
      end
      A_LO: begin
        wr_addr      = BTN_ADDR[7:0];
        w_state_next = A_WR;
      end
      A_WR: begin
        wr_en        = 1'b1;
        wr_addr      = BTN_ADDR[7:0];
        wr_data      = {4'hF, ~r_snap[3:0]};
        w_state_next = D_HI;
      end
      D_HI: begin
        wr_addr      = DIR_ADDR[15:8];
        w_state_next = D_LO;
      end
      D_LO: begin
        wr_addr      = DIR_ADDR[7:0];
        w_state_next = D_WR;
      end
      D_WR: begin
        wr_en        = 1'b1;
        wr_addr      = DIR_ADDR[7:0];
        wr_data      = {4'hF, ~r_snap[7:4]};
        w_state_next = IDLE;
      end
      default: begin
        busy         = 1'b0;
        w_state_next = IDLE;
      end
    endcase
  end

  // Changes seen mid-sequence are folded into a single rewrite after it ends.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_snap <= '0;
      r_init <= 1'b1;
      r_pend <= 1'b0;
    end else if (w_start) begin
      r_snap <= r_btn;
      r_init <= 1'b0;
      r_pend <= 1'b0;
    end else if (r_state != IDLE && r_chg) begin
      r_pend <= 1'b1;
    end
  end

  assign btn_state = r_btn;
  assign joy_irq   = r_irq;

endmodule

// File: tb/tb_joypad_scanner.sv
// Directed and random checks of joypad_scanner against a sliding-window
// debounce model and a phase-table model of the RAM write sequence.
module tb_joypad_scanner;

  localparam int unsigned D = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] btn_raw = 8'h00;
  logic [7:0] btn_state, wr_addr, wr_data;
  logic       wr_en, joy_irq, busy;

  always #5 clk = ~clk;

  joypad_scanner #(.BTN_ADDR(16'hFF00), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .btn_state(btn_state),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .joy_irq(joy_irq), .busy(busy)
  );

  int vectors = 0;
  int errs    = 0;

  // reference model state
  logic [7:0] m_s1, m_s2, m_state, m_snap;
  logic [7:0] m_hist [$];
  logic       m_irq, m_chg, m_pend;
  int         m_phase;

  logic [7:0] ram [logic [15:0]];
  logic [7:0] a1, a2;
  int         n_wr, n_irq, n_wr0;

  function automatic logic [7:0] act_b(input logic [7:0] s);
    return {4'hF, ~s[3:0]};
  endfunction

  function automatic logic [7:0] dir_b(input logic [7:0] s);
    return {4'hF, ~s[7:4]};
  endfunction

  // A bit flips once its last D synchronised samples all disagree with it.
  task automatic model_edge();
    logic [7:0] flip, nxt;
    if (!reset) begin
      m_s1 = '0; m_s2 = '0; m_state = '0; m_snap = '0;
      m_irq = 1'b0; m_chg = 1'b0; m_pend = 1'b1; m_phase = 0;
      m_hist = {};
      repeat (D) m_hist.push_back(8'h00);
    end else begin
      if (m_phase == 0) begin
        if (m_pend || m_chg) begin
          m_phase = 1; m_snap = m_state; m_pend = 1'b0;
        end
      end else begin
        if (m_chg) m_pend = 1'b1;
        m_phase = (m_phase == 6) ? 0 : m_phase + 1;
      end
      m_hist.push_back(m_s2);
      void'(m_hist.pop_front());
      flip = '1;
      foreach (m_hist[k]) flip &= m_hist[k] ^ m_state;
      nxt     = m_state ^ flip;
      m_irq   = |(nxt & ~m_state);
      m_chg   = (nxt != m_state);
      m_state = nxt;
      m_s2    = m_s1;
      m_s1    = btn_raw;
    end
  endtask

  task automatic check_all();
    logic [7:0] e_addr, e_data;
    logic       e_en;
    e_en = 1'b0; e_data = 8'h00; e_addr = 8'h00;
    case (m_phase)
      1: e_addr = 8'hFF;
      2: e_addr = 8'h00;
      3: begin e_addr = 8'h00; e_en = 1'b1; e_data = act_b(m_snap); end
      4: e_addr = 8'hFF;
      5: e_addr = 8'h01;
      6: begin e_addr = 8'h01; e_en = 1'b1; e_data = dir_b(m_snap); end
      default: e_addr = 8'h00;
    endcase
    vectors++;
    assert ({btn_state, joy_irq} === {m_state, m_irq}) else begin
      errs++;
      $error("FAIL debounce t=%0t got btn=%h irq=%b exp btn=%h irq=%b",
             $time, btn_state, joy_irq, m_state, m_irq);
    end
    vectors++;
    assert ({busy, wr_en, wr_addr, wr_data} === {(m_phase != 0), e_en, e_addr, e_data}) else begin
      errs++;
      $error("FAIL ram_port t=%0t got busy=%b en=%b addr=%h data=%h exp busy=%b en=%b addr=%h data=%h",
             $time, busy, wr_en, wr_addr, wr_data, (m_phase != 0), e_en, e_addr, e_data);
    end
    if (wr_en === 1'b1) begin
      ram[{a2, wr_addr}] = wr_data;
      n_wr++;
    end
    if (joy_irq === 1'b1) n_irq++;
    a2 = a1;
    a1 = wr_addr;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial begin
    ram[16'hFF00] = 8'h00;
    ram[16'hFF01] = 8'h00;
    a1 = 8'h00; a2 = 8'h00; n_wr = 0; n_irq = 0;

    // reset and power-up initialisation write
    reset = 1'b0;
    btn_raw = 8'h00;
    step(); step();
    chk("reset_outputs", 32'({btn_state, wr_en, wr_addr, wr_data, joy_irq, busy}), 32'd0);
    reset = 1'b1;
    step();
    chk("init_a_hi", 32'({busy, wr_addr}), 32'({1'b1, 8'hFF}));
    repeat (5) step();
    chk("init_act", 32'(ram[16'hFF00]), 32'(8'hFF));
    chk("init_dir", 32'(ram[16'hFF01]), 32'(8'hFF));
    step();
    chk("init_done", 32'({busy, 6'(n_wr), 6'(n_irq)}), 32'({1'b0, 6'd2, 6'd0}));

    // press A: visible after 2+D edges, with interrupt
    btn_raw = 8'h01;
    repeat (5) step();
    chk("a_before", 32'(btn_state), 32'(8'h00));
    step();
    chk("a_visible", 32'({btn_state, joy_irq}), 32'({8'h01, 1'b1}));
    repeat (7) step();
    chk("a_act", 32'(ram[16'hFF00]), 32'(8'hFE));
    chk("a_dir", 32'(ram[16'hFF01]), 32'(8'hFF));

    // 1- and 3-cycle glitches on Up must be rejected
    n_wr0 = n_wr; n_irq = 0;
    btn_raw = 8'h41; step();
    btn_raw = 8'h01; repeat (3) step();
    btn_raw = 8'h41; repeat (3) step();
    btn_raw = 8'h01; repeat (12) step();
    chk("glitch_state", 32'(btn_state), 32'(8'h01));
    chk("glitch_nowr", 32'(n_wr - n_wr0), 32'd0);
    chk("glitch_noirq", 32'(n_irq), 32'd0);

    // release A, then Down becomes visible during A_LO of the release write
    n_wr0 = n_wr; n_irq = 0;
    btn_raw = 8'h00; step(); step();
    btn_raw = 8'h80;
    repeat (11) step();
    chk("gap_idle", 32'(busy), 32'd0);
    step();
    chk("rewrite_start", 32'({busy, wr_addr}), 32'({1'b1, 8'hFF}));
    repeat (20) step();
    chk("down_act", 32'(ram[16'hFF00]), 32'(8'hFF));
    chk("down_dir", 32'(ram[16'hFF01]), 32'(8'hF7));
    chk("down_nwr", 32'(n_wr - n_wr0), 32'd4);
    chk("down_irq", 32'(n_irq), 32'd1);

    // reset asserted in D_LO aborts the direction write
    btn_raw = 8'h81;
    for (int i = 0; i < 30 && m_phase != 5; i++) step();
    chk("reach_d_lo", 32'({busy, wr_addr}), 32'({1'b1, 8'h01}));
    chk("partial_act", 32'(ram[16'hFF00]), 32'(8'hFE));
    reset = 1'b0;
    btn_raw = 8'h00;
    step();
    chk("reset_mid", 32'({btn_state, wr_en, wr_addr, wr_data, joy_irq, busy}), 32'd0);
    chk("no_partial_dir", 32'(ram[16'hFF01]), 32'(8'hF7));
    reset = 1'b1;
    repeat (7) step();
    chk("reinit_act", 32'(ram[16'hFF00]), 32'(8'hFF));
    chk("reinit_dir", 32'(ram[16'hFF01]), 32'(8'hFF));

    // random button activity with occasional resets
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 5) == 0) btn_raw = 8'($urandom);
      reset = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      step();
    end
    reset = 1'b1;
    repeat (40) step();
    chk("final_act", 32'(ram[16'hFF00]), 32'(act_b(m_state)));
    chk("final_dir", 32'(ram[16'hFF01]), 32'(dir_b(m_state)));
    chk("final_state", 32'(btn_state), 32'(btn_raw));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
